// File: rtl/full_adder_1.sv
// rtl/full_adder_1.sv - single-bit full adder with registered, bit-serial carry-chained path
module full_adder_1 (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic serial_en,
    input  logic first,
    output logic sum_comb,
    output logic cout_comb,
    output logic sum,
    output logic cout,
    output logic out_valid
);

    logic carry_q;
    logic ci_eff;

    // Serial beats chain through carry_q; a first beat (or parallel mode) restarts from cin.
    always_comb begin
        ci_eff = cin;
        if (serial_en && !first) begin
            ci_eff = carry_q;
        end
    end

    always_comb begin
        sum_comb  = a ^ b ^ ci_eff;
        cout_comb = (a & b) | (a & ci_eff) | (b & ci_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= 1'b0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum     <= sum_comb;
                cout    <= cout_comb;
                carry_q <= cout_comb;
            end
        end
    end

endmodule

// File: tb/tb_full_adder_1.sv
// tb/tb_full_adder_1.sv - randomized and directed bench for full_adder_1 against an arithmetic model
module tb_full_adder_1;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic a;
    logic b;
    logic cin;
    logic serial_en;
    logic first;
    logic sum_comb;
    logic cout_comb;
    logic sum;
    logic cout;
    logic out_valid;

    int pass_cnt;
    int total_cnt;

    // Reference state: the carry an operand stream would have accumulated, and the last result.
    int m_carry;
    int e_sum;
    int e_cout;
    int e_ov;

    full_adder_1 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .serial_en (serial_en),
        .first     (first),
        .sum_comb  (sum_comb),
        .cout_comb (cout_comb),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_total();
        int ci;
        ci = (serial_en && !first) ? m_carry : int'(cin);
        return int'(a) + int'(b) + ci;
    endfunction

    task automatic drive(input logic v, input logic ia, input logic ib, input logic ic,
                         input logic se, input logic fst);
        @(negedge clk);
        in_valid  = v;
        a         = ia;
        b         = ib;
        cin       = ic;
        serial_en = se;
        first     = fst;
        #1;
    endtask

    task automatic step();
        int t;
        t = model_total();
        @(posedge clk);
        if (in_valid) begin
            e_sum   = t % 2;
            e_cout  = t / 2;
            m_carry = t / 2;
        end
        e_ov = int'(in_valid);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_carry = 0; e_sum = 0; e_cout = 0; e_ov = 0;
        total_cnt++;
        if ({sum, cout, out_valid} !== 3'b000) $display("FAIL reset_outputs got=%b want=000", {sum, cout, out_valid});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_exhaustive();
        logic [7:0] sums;
        logic [7:0] couts;
        sums  = 8'b1001_0110;
        couts = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            drive(1'b1, v[2], v[1], v[0], 1'b0, 1'b0);
            total_cnt++;
            if ({cout_comb, sum_comb} !== {couts[i], sums[i]})
                $display("FAIL exh_comb i=%0d got=%b%b want=%b%b", i, cout_comb, sum_comb, couts[i], sums[i]);
            else pass_cnt++;
            step();
            total_cnt++;
            if ({cout, sum, out_valid} !== {couts[i], sums[i], 1'b1})
                $display("FAIL exh_reg i=%0d got=%b%b%b want=%b%b1", i, cout, sum, out_valid, couts[i], sums[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 1'b0);
            step();
            total_cnt++;
            if ({sum, cout, out_valid} !== 3'b110)
                $display("FAIL hold cyc=%0d got=%b want=110", i, {sum, cout, out_valid});
            else pass_cnt++;
        end
    endtask

    task automatic test_serial_add();
        logic [3:0] av;
        logic [3:0] bv;
        logic [4:0] got;
        av = 4'b1011;
        bv = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, av[i], bv[i], 1'b0, 1'b1, i == 0);
            step();
            got[i] = sum;
            got[4] = cout;
        end
        total_cnt++;
        if (got !== 5'd17) $display("FAIL serial_add got=%0d want=17", got);
        else pass_cnt++;
    endtask

    task automatic test_restart();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        total_cnt++;
        if ({sum, cout} !== 2'b00) $display("FAIL restart got=%b want=00", {sum, cout});
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        total_cnt++;
        if ({sum, cout, out_valid} !== 3'b111) $display("FAIL pre_reset got=%b want=111", {sum, cout, out_valid});
        else pass_cnt++;
        #1;
        rst_n = 1'b0;
        m_carry = 0; e_sum = 0; e_cout = 0; e_ov = 0;
        #1;
        total_cnt++;
        if ({sum, cout, out_valid} !== 3'b000) $display("FAIL async_reset got=%b want=000", {sum, cout, out_valid});
        else pass_cnt++;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        step();
        total_cnt++;
        if ({sum, cout} !== 2'b10) $display("FAIL post_reset_beat got=%b want=10", {sum, cout});
        else pass_cnt++;
    endtask

    task automatic test_mode_mix();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        total_cnt++;
        if ({sum, cout} !== 2'b10) $display("FAIL mix_parallel got=%b want=10", {sum, cout});
        else pass_cnt++;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        total_cnt++;
        if ({sum, cout} !== 2'b10) $display("FAIL mix_serial got=%b want=10", {sum, cout});
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int t;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
            t = model_total();
            total_cnt++;
            if ({cout_comb, sum_comb} !== 2'(t))
                $display("FAIL rand_comb i=%0d got=%b%b want=%0d", i, cout_comb, sum_comb, t);
            else pass_cnt++;
            step();
            total_cnt++;
            if ({sum, cout, out_valid} !== {1'(e_sum), 1'(e_cout), 1'(e_ov)})
                $display("FAIL rand_reg i=%0d got=%b want=%0d%0d%0d", i, {sum, cout, out_valid}, e_sum, e_cout, e_ov);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back_serial();
        for (int op = 0; op < 10; op++) begin
            logic [7:0] av;
            logic [7:0] bv;
            logic [8:0] got;
            logic [8:0] want;
            av = 8'($urandom);
            bv = 8'($urandom);
            want = 9'(av) + 9'(bv);
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                    step();
                end
                drive(1'b1, av[i], bv[i], 1'b0, 1'b1, i == 0);
                step();
                got[i] = sum;
                got[8] = cout;
            end
            total_cnt++;
            if (got !== want) $display("FAIL serial8 op=%0d got=%0d want=%0d", op, got, want);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a = 1'b0; b = 1'b0; cin = 1'b0; serial_en = 1'b0; first = 1'b0;
        test_reset();
        test_exhaustive();
        test_hold();
        test_serial_add();
        test_restart();
        test_async_reset();
        test_mode_mix();
        test_random();
        test_back_to_back_serial();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/full_adder_1.md
# full_adder_1

Single-bit full adder stage with a combinational result path and a registered, valid-qualified result path. It supports a bit-serial mode: an internal carry register chains successive beats so multi-bit operands can be added LSB-first through one stage. It is the leaf arithmetic cell for adder chains and serial arithmetic datapaths.

## Interface
- Parameters: none.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat qualifier for a, b, cin, first.
- a  input  1  addend bit.
- b  input  1  addend bit.
- cin  input  1  carry-in; ignored in serial mode except on a `first` beat.
- serial_en  input  1  1 = carry taken from internal carry register; 0 = carry taken from cin.
- first  input  1  serial mode only: marks the LSB beat, so cin is used instead of the stored carry.
- sum_comb  output  1  combinational sum of current inputs.
- cout_comb  output  1  combinational carry-out of current inputs.
- sum  output  1  registered sum.
- cout  output  1  registered carry-out.
- out_valid  output  1  registered beat qualifier for sum and cout.

## Operation
- Effective carry:
  - ci_eff = cin when serial_en = 0.
  - ci_eff = cin when serial_en = 1 and first = 1.
  - ci_eff = carry_q otherwise.
- sum_comb = a ^ b ^ ci_eff.
- cout_comb = (a & b) | (a & ci_eff) | (b & ci_eff).
- The combinational outputs are independent of in_valid.
- The 2-bit arithmetic result {cout_comb, sum_comb} always equals a + b + ci_eff (range 0..3).
- On a rising clk edge with in_valid = 1:
  - sum <= sum_comb, cout <= cout_comb, out_valid <= 1.
  - carry_q <= cout_comb, in both modes.
- On a rising clk edge with in_valid = 0:
  - out_valid <= 0.
  - sum, cout and carry_q hold.
- Serial addition:
  - Assert first with bit 0 and stream bits LSB-first on consecutive or non-consecutive valid beats.
  - The final carry is the cout of the last beat.
  - Asserting first starts a new operand, regardless of the previous sequence state.
- Toggling serial_en between beats is legal; each beat uses the ci_eff rule above.
- first is ignored when serial_en = 0.
- X-free: all outputs are driven from defined state after reset.

## Timing
- Combinational path: sum_comb and cout_comb settle in the same cycle as input change; no clock involvement.
- Registered path latency: 1 cycle. Inputs sampled at edge N appear on sum, cout and out_valid after edge N.
- Throughput: one beat per cycle.
- Reset (async assertion, any time): sum = 0, cout = 0, out_valid = 0, carry_q = 0 immediately, with no clock required.
- Reset release: takes effect synchronously at the next edge where rst_n = 1.
- Reset mid-serial-sequence: the stored carry is lost (carry_q = 0). A beat without first after reset therefore uses carry 0.

## Test plan
- Exhaustive combinational check, serial_en = 0:
  - Step {a,b,cin} through 0..7, one value per cycle, with in_valid = 1.
  - sum_comb/cout_comb follow the sequence 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
  - Registered sum/cout show the same sequence one cycle later, with out_valid = 1 on each beat.
- Hold check:
  - Valid beat a=1, b=1, cin=1, then in_valid = 0 for 3 cycles.
  - sum = 1 and cout = 1 hold; out_valid = 0 after the first idle edge.
- Serial 4-bit add, 1011 + 0110, LSB-first:
  - Beats: first = 1 with cin = 0; then (a,b) = (1,0), (1,1), (0,1), (1,0).
  - Registered sum bits 1, 0, 0, 0; final cout = 1 (result 10001 = 17).
- Serial restart:
  - After a sequence ending with carry_q = 1, send a first beat with a=0, b=0, cin=0.
  - sum = 0, cout = 0; the stored carry is not used.
- Async reset mid-operation:
  - Assert rst_n = 0 between clock edges while sum = cout = out_valid = 1 and carry_q = 1.
  - All outputs go to 0 immediately.
  - Next serial beat a=1, b=0 without first gives sum = 1, cout = 0.
- Mode mixing:
  - serial_en = 0 with cin = 1, a=0, b=0 gives sum = 1, regardless of carry_q.
  - Then serial_en = 1 without first uses the carry_q produced by that beat (0).
